sram_rd_streamer: RTL and testbench



---
 rtl/sram_rd_streamer.sv | 106 ++++++++++
 tb/tb_sram_rd_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_streamer.sv
// Burst read streamer for the packet-buffer SRAM: request in, valid/ready word stream out.
// Latency: 3 cycles from request accept to first out_valid; 1 word/cycle when unstalled.
// Backpressure: a 2-entry output FIFO plus in-flight read is never oversubscribed; issue stalls until a pop.
module sram_rd_streamer #(
    parameter int AW = 14,
    parameter int DW = 16,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] sram_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remaining;
    logic [1:0]    count;
    logic          inflight;
    logic          inflight_last;
    logic [DW:0]   fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          pop;
    logic          push;

    assign pop  = out_valid && out_ready;
    assign push = inflight;

    // Space for the returning word is reserved at issue time, so a same-cycle pop frees a slot.
    assign rd_en = (state == BURST) && rst_n &&
                   (((count + 2'(inflight)) <= 2'd1) || pop);

    assign req_ready = (state == IDLE) && rst_n;
    assign rd_addr   = rst_n ? cur_addr : '0;
    assign out_valid = rst_n && (count != 2'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr][DW-1:0] : '0;
    assign out_last  = out_valid && fifo_mem[rd_ptr][DW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            count         <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_mem[0]   <= '0;
            fifo_mem[1]   <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inflight_last <= (remaining == '0);
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr  <= req_addr;
                        remaining <= req_len;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (rd_en) begin
                        cur_addr <= cur_addr + 1'b1;
                        if (remaining == '0) begin
                            state <= IDLE;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                fifo_mem[wr_ptr] <= {inflight_last, sram_dout};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rd_streamer.sv
module tb_sram_rd_streamer;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] sram_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int addr;
        int len;
        int stall_start;
        int stall_len;
        int exp_first;
        int exp_last;
        int exp_rdy;
    } vec_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            iss_cnt = 0;
    int            pop_cnt = 0;
    logic          hold_vld = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    exp_t          mon_e;
    vec_t          vecs[6];

    always #5 clk = ~clk;

    sram_rd_streamer #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .sram_dout (sram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'(32'(a) + 1000);
    endfunction

    // SRAM model with one-cycle registered read
    always @(posedge clk) begin
        if (rd_en) sram_dout <= mem_word(rd_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Scoreboard monitor: addresses and words are checked in order as the DUT produces them
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            iss_cnt  = 0;
            pop_cnt  = 0;
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("stall_valid_held", 32'(out_valid), 1);
                check("stall_data_held", 32'(out_data), 32'(hold_data));
                check("stall_last_held", 32'(out_last), 32'(hold_last));
            end
            if (rd_en) begin
                if (addr_q.size() == 0) check("rd_en_without_pending_addr", 32'(rd_en), 0);
                else check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
                iss_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("word_without_expectation", 32'(out_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_last", 32'(out_last), 32'(mon_e.last));
                end
                pop_cnt++;
            end
            check("occupancy_le_2", 32'((iss_cnt - pop_cnt) <= 2), 1);
            hold_vld  = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    task automatic push_req(input int addr, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i <= len; i++) begin
            a = 14'(addr + i);
            addr_q.push_back(a);
            exp_q.push_back('{data: mem_word(a), last: (i == len)});
        end
        req_valid = 1'b1;
        req_addr  = 14'(addr);
        req_len   = 6'(len);
    endtask

    task automatic run_vec(input vec_t v);
        int first_out, last_out, rdy, first_iss, last_iss, n_iss;
        bit done;
        first_out = -1; last_out = -1; rdy = -1; first_iss = -1; last_iss = -1;
        n_iss = 0; done = 1'b0;
        @(posedge clk); #1;
        push_req(v.addr, v.len);
        out_ready = 1'b1;
        @(negedge clk);
        check("req_ready_before_accept", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int rel = 1; rel <= 300 && !done; rel++) begin
            out_ready = !(rel >= v.stall_start && rel < v.stall_start + v.stall_len);
            @(negedge clk);
            if (rd_en) begin
                if (first_iss < 0) first_iss = rel;
                last_iss = rel;
                n_iss++;
            end
            if (req_ready && rdy < 0) rdy = rel;
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = rel;
                if (out_last) begin
                    last_out = rel;
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        check("burst_done_in_budget", 32'(done), 1);
        check("first_issue_cycle", 32'(first_iss), 1);
        check("last_issue_cycle", 32'(last_iss), 32'(v.exp_rdy - 1));
        check("issue_count", 32'(n_iss), 32'(v.len + 1));
        check("req_ready_return_cycle", 32'(rdy), 32'(v.exp_rdy));
        check("first_out_cycle", 32'(first_out), 32'(v.exp_first));
        check("last_out_cycle", 32'(last_out), 32'(v.exp_last));
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("addr_queue_empty", 32'(addr_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input bit in_reset);
        check("rst_req_ready", 32'(req_ready), in_reset ? 0 : 1);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
    endtask

    task automatic back_to_back();
        int accepted, b_acc_rel, lasts, npop;
        bit b_pushed;
        accepted = 0; b_acc_rel = -1; lasts = 0; npop = 0; b_pushed = 1'b0;
        @(posedge clk); #1;
        push_req(300, 1);
        out_ready = 1'b1;
        for (int rel = 0; rel <= 100 && lasts < 2; rel++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                accepted++;
                if (accepted == 2) b_acc_rel = rel;
            end
            if (out_valid && out_ready) begin
                npop++;
                if (out_last) lasts++;
            end
            @(posedge clk); #1;
            if (accepted == 1 && !b_pushed) begin
                push_req(400, 2);
                b_pushed = 1'b1;
            end
            if (accepted == 2) req_valid = 1'b0;
        end
        check("b2b_second_accept_cycle", 32'(b_acc_rel), 3);
        check("b2b_words", 32'(npop), 5);
        check("b2b_last_markers", 32'(lasts), 2);
        check("b2b_scoreboard_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic reset_mid_burst();
        vec_t nv;
        @(posedge clk); #1;
        push_req(500, 15);
        out_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("full_rd_en_blocked", 32'(rd_en), 0);
        check("full_out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs(1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs(1'b0);
        nv = '{50, 2, 0, 0, 3, 5, 4};
        run_vec(nv);
    endtask

    initial begin
        vecs[0] = '{5,     0,  0, 0, 3, 3,  2};
        vecs[1] = '{100,   3,  0, 0, 3, 6,  5};
        vecs[2] = '{200,   7,  4, 6, 3, 16, 15};
        vecs[3] = '{16382, 3,  0, 0, 3, 6,  5};
        vecs[4] = '{16380, 63, 10, 3, 3, 69, 68};
        vecs[5] = '{0,     1,  4, 1, 3, 5,  3};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs(1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs(1'b0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end
        back_to_back();
        reset_mid_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
